// File: rtl/rv_decode_stage.sv
// ============================================================================
// rv_decode_stage
//
// Registered RISC-V decode stage placed between instruction fetch and
// register-read/ALU. Each accepted instruction is decoded combinationally
// into register indices, control strobes, a sign-extended immediate and the
// PC-relative target. The decoded bundle is registered and presented one
// clock later. A one-entry skid buffer keeps the stage at one instruction
// per clock under backpressure.
//
// Parameters:
//   XLEN          datapath width of pc/imm/target (32 or 64)
//   RESET_PC_TAG  value shown on out_pc whenever out_valid is low
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   in_valid/in_ready        upstream handshake
//   in_instr, in_pc          instruction word and its address
//   out_valid/out_ready      downstream handshake
//   out_pc                   PC of the decoded instruction
//   out_rs1/rs2/rd           register indices
//   out_funct3/out_funct7    raw function fields
//   out_imm, out_target      sign-extended immediate, out_pc + out_imm
//   out_fmt                  0=R 1=I 2=S 3=B 4=U 5=J 7=none
//   out_alu_src .. out_jump  control strobes
//   out_alu_op               00 add, 01 branch cmp, 10 funct, 11 pass imm
//   out_illegal              instruction not supported
//
// Optional feature (macro DECODE_PERF_CNT_EN):
//   out_retire_cnt, out_illegal_cnt  saturating 32-bit transfer counters
// ============================================================================
module rv_decode_stage #(
    parameter int unsigned     XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic [2:0]      out_fmt,
    output logic            out_alu_src,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_mem_to_reg,
    output logic            out_reg_write,
    output logic            out_branch,
    output logic            out_jump,
    output logic [1:0]      out_alu_op,
    output logic            out_illegal
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]     out_retire_cnt,
    output logic [31:0]     out_illegal_cnt
`endif
);

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10,
        ALU_LUI    = 2'b11
    } alu_op_e;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        fmt_e            fmt;
        logic            alu_src;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            reg_write;
        logic            branch;
        logic            jump;
        alu_op_e         alu_op;
        logic            illegal;
    } bundle_t;

    // Bundle shown while the output is empty; also the reset value.
    function automatic bundle_t idle_bundle();
        bundle_t b;
        b     = '0;
        b.pc  = RESET_PC_TAG;
        b.fmt = FMT_NONE;
        return b;
    endfunction

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    bundle_t         dec;
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic            known_op;
    logic            bad_f3;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_x;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        opcode   = in_instr[6:0];
        f3       = in_instr[14:12];
        known_op = 1'b1;
        bad_f3   = 1'b0;
        imm32    = '0;
        dec      = '0;

        dec.pc     = in_pc;
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.rd     = in_instr[11:7];
        dec.funct3 = f3;
        dec.funct7 = in_instr[31:25];
        dec.fmt    = FMT_NONE;
        dec.alu_op = ALU_ADD;

        unique case (opcode)
            OP_REG: begin
                dec.fmt       = FMT_R;
                dec.alu_op    = ALU_FUNCT;
                dec.reg_write = 1'b1;
            end
            OP_IMM: begin
                dec.fmt       = FMT_I;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_FUNCT;
                dec.reg_write = 1'b1;
            end
            OP_LOAD: begin
                dec.fmt        = FMT_I;
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                bad_f3 = (f3 == 3'b111) ||
                         ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
            end
            OP_STORE: begin
                dec.fmt       = FMT_S;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                bad_f3 = (f3 > 3'b011) || ((XLEN == 32) && (f3 == 3'b011));
            end
            OP_BRANCH: begin
                dec.fmt    = FMT_B;
                dec.branch = 1'b1;
                dec.alu_op = ALU_BRANCH;
                bad_f3 = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_LUI: begin
                dec.fmt       = FMT_U;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_LUI;
                dec.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                // Result is out_target (pc + imm); no ALU operand select.
                dec.fmt       = FMT_U;
                dec.reg_write = 1'b1;
            end
            OP_JAL: begin
                dec.fmt       = FMT_J;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_JALR: begin
                dec.fmt       = FMT_I;
                dec.jump      = 1'b1;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: known_op = 1'b0;
        endcase

        // Immediate is rebuilt from the live instruction word every time.
        unique case (dec.fmt)
            FMT_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U:   imm32 = {in_instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase

        imm_x       = {XLEN{imm32[31]}};
        imm_x[31:0] = imm32;
        dec.imm     = imm_x;
        dec.target  = in_pc + imm_x;   // wraps modulo 2^XLEN

        dec.illegal = ~known_op || (in_instr[1:0] != 2'b11) || bad_f3;
        if (dec.illegal) begin
            dec.fmt        = FMT_NONE;
            dec.mem_read   = 1'b0;
            dec.mem_write  = 1'b0;
            dec.mem_to_reg = 1'b0;
            dec.reg_write  = 1'b0;
            dec.branch     = 1'b0;
            dec.jump       = 1'b0;
        end
        if (dec.rd == 5'd0) begin
            dec.reg_write = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output register + skid entry. {out_valid_q, skid_valid_q} encodes
    // EMPTY (00), ONE (10) and TWO (11).
    // ------------------------------------------------------------------
    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    logic    out_valid_q, out_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    out_upd;
    logic    accept;

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign out_upd  = ~out_valid_q | out_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (out_upd) begin
            if (skid_valid_q) begin
                // in_ready is low while the skid is full, so no input races it.
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_d       = idle_bundle();
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_d       = idle_bundle();
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the data registers are reset as well as the valids, so
            // the reset bundle (fmt=7, imm=0, pc tag) is visible downstream.
            out_q        <= idle_bundle();
            out_valid_q  <= 1'b0;
            skid_q       <= idle_bundle();
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_pc         = out_q.pc;
    assign out_rs1        = out_q.rs1;
    assign out_rs2        = out_q.rs2;
    assign out_rd         = out_q.rd;
    assign out_funct3     = out_q.funct3;
    assign out_funct7     = out_q.funct7;
    assign out_imm        = out_q.imm;
    assign out_target     = out_q.target;
    assign out_fmt        = out_q.fmt;
    assign out_alu_src    = out_q.alu_src;
    assign out_mem_read   = out_q.mem_read;
    assign out_mem_write  = out_q.mem_write;
    assign out_mem_to_reg = out_q.mem_to_reg;
    assign out_reg_write  = out_q.reg_write;
    assign out_branch     = out_q.branch;
    assign out_jump       = out_q.jump;
    assign out_alu_op     = out_q.alu_op;
    assign out_illegal    = out_q.illegal;

`ifdef DECODE_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating transfer counters
    // ------------------------------------------------------------------
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic [31:0] illegal_cnt_q, illegal_cnt_d;
    logic        xfer;

    assign xfer = out_valid_q & out_ready;

    always_comb begin
        retire_cnt_d  = retire_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        if (xfer && (retire_cnt_q != 32'hFFFF_FFFF)) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
        if (xfer && out_q.illegal && (illegal_cnt_q != 32'hFFFF_FFFF)) begin
            illegal_cnt_d = illegal_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q  <= '0;
            illegal_cnt_q <= '0;
        end else begin
            retire_cnt_q  <= retire_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign out_retire_cnt  = retire_cnt_q;
    assign out_illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_rv_decode_stage.sv
// ============================================================================
// tb_rv_decode_stage
//
// Directed bench for rv_decode_stage. A 64-bit instance carries most of the
// scenarios; a 32-bit instance covers the XLEN-dependent store legality.
// Expected values are hand-decoded from the instruction encodings.
// ============================================================================
module tb_rv_decode_stage;

    localparam logic [63:0] TAG = 64'h0000_0000_DEAD_0000;

    logic clk;
    logic rst;

    // 64-bit instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc, out_pc, out_imm, out_target;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_funct3, out_fmt;
    logic [6:0]  out_funct7;
    logic        out_alu_src, out_mem_read, out_mem_write, out_mem_to_reg;
    logic        out_reg_write, out_branch, out_jump, out_illegal;
    logic [1:0]  out_alu_op;

    // 32-bit instance
    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] in_instr32, in_pc32, out_pc32, out_imm32, out_target32;
    logic [4:0]  out_rs1_32, out_rs2_32, out_rd32;
    logic [2:0]  out_funct3_32, out_fmt32;
    logic [6:0]  out_funct7_32;
    logic        out_alu_src32, out_mem_read32, out_mem_write32, out_mem_to_reg32;
    logic        out_reg_write32, out_branch32, out_jump32, out_illegal32;
    logic [1:0]  out_alu_op32;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] retire_cnt, illegal_cnt, retire_cnt32, illegal_cnt32;
`endif

    // {alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, jump}
    logic [6:0] strb, strb32;
    assign strb   = {out_alu_src, out_mem_read, out_mem_write, out_mem_to_reg,
                     out_reg_write, out_branch, out_jump};
    assign strb32 = {out_alu_src32, out_mem_read32, out_mem_write32, out_mem_to_reg32,
                     out_reg_write32, out_branch32, out_jump32};

    int checks   = 0;
    int failures = 0;

    rv_decode_stage #(.XLEN(64), .RESET_PC_TAG(TAG)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_imm(out_imm), .out_target(out_target), .out_fmt(out_fmt),
        .out_alu_src(out_alu_src), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
        .out_reg_write(out_reg_write), .out_branch(out_branch), .out_jump(out_jump),
        .out_alu_op(out_alu_op), .out_illegal(out_illegal)
`ifdef DECODE_PERF_CNT_EN
        , .out_retire_cnt(retire_cnt), .out_illegal_cnt(illegal_cnt)
`endif
    );

    rv_decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid32), .in_ready(in_ready32), .in_instr(in_instr32), .in_pc(in_pc32),
        .out_valid(out_valid32), .out_ready(out_ready32), .out_pc(out_pc32),
        .out_rs1(out_rs1_32), .out_rs2(out_rs2_32), .out_rd(out_rd32),
        .out_funct3(out_funct3_32), .out_funct7(out_funct7_32),
        .out_imm(out_imm32), .out_target(out_target32), .out_fmt(out_fmt32),
        .out_alu_src(out_alu_src32), .out_mem_read(out_mem_read32),
        .out_mem_write(out_mem_write32), .out_mem_to_reg(out_mem_to_reg32),
        .out_reg_write(out_reg_write32), .out_branch(out_branch32), .out_jump(out_jump32),
        .out_alu_op(out_alu_op32), .out_illegal(out_illegal32)
`ifdef DECODE_PERF_CNT_EN
        , .out_retire_cnt(retire_cnt32), .out_illegal_cnt(illegal_cnt32)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [63:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 64'h0);
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (strb !== 7'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=0000000", strb); end
        checks++; if (out_fmt !== 3'd7) begin failures++; $display("FAIL reset_fmt got=%0d exp=7", out_fmt); end
        checks++; if (out_imm !== 64'h0 || out_target !== 64'h0) begin failures++; $display("FAIL reset_imm_target got=%h/%h exp=0/0", out_imm, out_target); end
        checks++; if (out_pc !== TAG) begin failures++; $display("FAIL reset_pc got=%h exp=%h", out_pc, TAG); end
        checks++; if (out_illegal !== 1'b0 || out_alu_op !== 2'b00) begin failures++; $display("FAIL reset_illegal_aluop got=%0b/%b exp=0/00", out_illegal, out_alu_op); end
        rst = 1'b0;
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF00293, 64'h1000);   // addi x5,x0,-1
        tick();
        drive(1'b0, 32'h0, 64'h0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0b exp=1", out_valid); end
        checks++; if (out_fmt !== 3'd1) begin failures++; $display("FAIL addi_fmt got=%0d exp=1", out_fmt); end
        checks++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL addi_imm got=%h exp=ffffffffffffffff", out_imm); end
        checks++; if (out_rd !== 5'd5 || out_rs1 !== 5'd0) begin failures++; $display("FAIL addi_regs got=rd%0d rs1%0d exp=rd5 rs1 0", out_rd, out_rs1); end
        checks++; if (strb !== 7'b1000100) begin failures++; $display("FAIL addi_strobes got=%b exp=1000100", strb); end
        checks++; if (out_alu_op !== 2'b10) begin failures++; $display("FAIL addi_alu_op got=%b exp=10", out_alu_op); end
        checks++; if (out_target !== 64'h0FFF || out_pc !== 64'h1000) begin failures++; $display("FAIL addi_target_pc got=%h/%h exp=fff/1000", out_target, out_pc); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_pc !== TAG) begin failures++; $display("FAIL addi_drain got=%0b/%h exp=0/%h", out_valid, out_pc, TAG); end
    endtask

    task automatic test_branch();
        out_ready = 1'b1;
        drive(1'b1, 32'hFE208CE3, 64'h100);    // beq x1,x2,-8
        tick();
        drive(1'b0, 32'h0, 64'h0);
        checks++; if (out_fmt !== 3'd3) begin failures++; $display("FAIL beq_fmt got=%0d exp=3", out_fmt); end
        checks++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin failures++; $display("FAIL beq_imm got=%h exp=fffffffffffffff8", out_imm); end
        checks++; if (out_target !== 64'hF8) begin failures++; $display("FAIL beq_target got=%h exp=f8", out_target); end
        checks++; if (strb !== 7'b0000010) begin failures++; $display("FAIL beq_strobes got=%b exp=0000010", strb); end
        checks++; if (out_alu_op !== 2'b01 || out_illegal !== 1'b0) begin failures++; $display("FAIL beq_aluop_ill got=%b/%0b exp=01/0", out_alu_op, out_illegal); end
        checks++; if (out_rs1 !== 5'd1 || out_rs2 !== 5'd2 || out_funct3 !== 3'd0 || out_funct7 !== 7'h7F) begin
            failures++; $display("FAIL beq_fields got=rs1 %0d rs2 %0d f3 %0d f7 %h exp=1 2 0 7f", out_rs1, out_rs2, out_funct3, out_funct7);
        end
        tick();
    endtask

    task automatic test_store();
        out_ready   = 1'b1;
        out_ready32 = 1'b1;
        drive(1'b1, 32'h00313823, 64'h40);     // sd x3,16(x2)
        in_valid32 = 1'b1;
        in_instr32 = 32'h00313823;
        in_pc32    = 32'h40;
        tick();
        drive(1'b0, 32'h0, 64'h0);
        in_valid32 = 1'b0;
        checks++; if (out_imm !== 64'd16 || out_target !== 64'h50) begin failures++; $display("FAIL sd64_imm got=%h/%h exp=10/50", out_imm, out_target); end
        checks++; if (strb !== 7'b1010000 || out_fmt !== 3'd2 || out_illegal !== 1'b0) begin
            failures++; $display("FAIL sd64_ctrl got=%b fmt%0d ill%0b exp=1010000 fmt2 ill0", strb, out_fmt, out_illegal);
        end
        checks++; if (out_valid32 !== 1'b1 || out_illegal32 !== 1'b1) begin failures++; $display("FAIL sd32_illegal got=%0b/%0b exp=1/1", out_valid32, out_illegal32); end
        checks++; if (out_mem_write32 !== 1'b0 || out_fmt32 !== 3'd7) begin failures++; $display("FAIL sd32_ctrl got=mw%0b fmt%0d exp=mw0 fmt7", out_mem_write32, out_fmt32); end
        checks++; if (out_rs1_32 !== 5'd2 || out_rs2_32 !== 5'd3 || out_pc32 !== 32'h40) begin
            failures++; $display("FAIL sd32_fields got=%0d %0d %h exp=2 3 40", out_rs1_32, out_rs2_32, out_pc32);
        end
        tick();
        checks++; if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin failures++; $display("FAIL sd32_drain got=%0b/%0b exp=0/1", out_valid32, in_ready32); end
    endtask

    // Continuous stream with out_ready=1: ONE stays ONE while accepting and draining.
    task automatic test_back_to_back();
        logic [31:0] instrs [6];
        logic [63:0] pcs    [6];
        logic [2:0]  e_fmt  [6];
        logic [63:0] e_imm  [6];
        logic [63:0] e_tgt  [6];
        logic [6:0]  e_strb [6];
        logic        e_ill  [6];
        instrs = '{32'h800000B7, 32'hFFDFF0EF, 32'h0000007F, 32'h00000013, 32'hFE20ACE3, 32'hFE208CE3};
        pcs    = '{64'h3000, 64'h2000, 64'h0, 64'h0, 64'h0, 64'h0};
        e_fmt  = '{3'd4, 3'd5, 3'd7, 3'd1, 3'd7, 3'd3};
        e_imm  = '{64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0,
                   64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8};
        e_tgt  = '{64'hFFFF_FFFF_8000_3000, 64'h1FFC, 64'h0, 64'h0,
                   64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8};
        e_strb = '{7'b1000100, 7'b0000101, 7'b0000000, 7'b1000000, 7'b0000000, 7'b0000010};
        e_ill  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, instrs[i], pcs[i]);
            tick();
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b%0d_hs got=%0b/%0b exp=1/1", i, out_valid, in_ready); end
            checks++; if (out_fmt !== e_fmt[i] || out_illegal !== e_ill[i]) begin
                failures++; $display("FAIL b2b%0d_fmt got=%0d/%0b exp=%0d/%0b", i, out_fmt, out_illegal, e_fmt[i], e_ill[i]);
            end
            checks++; if (out_imm !== e_imm[i] || out_target !== e_tgt[i]) begin
                failures++; $display("FAIL b2b%0d_imm got=%h/%h exp=%h/%h", i, out_imm, out_target, e_imm[i], e_tgt[i]);
            end
            checks++; if (strb !== e_strb[i]) begin failures++; $display("FAIL b2b%0d_strobes got=%b exp=%b", i, strb, e_strb[i]); end
        end
        drive(1'b0, 32'h0, 64'h0);
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 64'h10);     // A: addi x1,x0,1
        tick();
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd1 || in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_one got=v%0b rd%0d rdy%0b exp=v1 rd1 rdy1", out_valid, out_rd, in_ready);
        end
        drive(1'b1, 32'h00100113, 64'h14);     // B: addi x2,x0,1
        tick();
        checks++; if (out_rd !== 5'd1 || out_pc !== 64'h10 || in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_two got=rd%0d pc%h rdy%0b exp=rd1 pc10 rdy0", out_rd, out_pc, in_ready);
        end
        drive(1'b1, 32'h00100193, 64'h18);     // C: addi x3,x0,1 (refused)
        tick();
        checks++; if (out_rd !== 5'd1 || out_imm !== 64'd1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++; $display("FAIL bp_hold got=rd%0d imm%h rdy%0b v%0b exp=rd1 imm1 rdy0 v1", out_rd, out_imm, in_ready, out_valid);
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_rd !== 5'd2 || out_pc !== 64'h14 || in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_skid_out got=rd%0d pc%h rdy%0b exp=rd2 pc14 rdy1", out_rd, out_pc, in_ready);
        end
        tick();
        checks++; if (out_rd !== 5'd3 || out_pc !== 64'h18 || out_valid !== 1'b1) begin
            failures++; $display("FAIL bp_third got=rd%0d pc%h v%0b exp=rd3 pc18 v1", out_rd, out_pc, out_valid);
        end
        drive(1'b0, 32'h0, 64'h0);
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_reset_in_two();
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 64'h20);
        tick();
        drive(1'b1, 32'h00100113, 64'h24);
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL rst2_pre got=%0b/%0b exp=0/1", in_ready, out_valid); end
        rst = 1'b1;
        drive(1'b0, 32'h0, 64'h0);
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rst2_hs got=%0b/%0b exp=0/1", out_valid, in_ready); end
        checks++; if (strb !== 7'b0 || out_fmt !== 3'd7 || out_pc !== TAG) begin
            failures++; $display("FAIL rst2_bundle got=%b fmt%0d pc%h exp=0000000 fmt7 pc%h", strb, out_fmt, out_pc, TAG);
        end
        out_ready = 1'b1;
        drive(1'b1, 32'h00100193, 64'h80);
        tick();
        drive(1'b0, 32'h0, 64'h0);
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd3 || out_pc !== 64'h80) begin
            failures++; $display("FAIL rst2_first got=v%0b rd%0d pc%h exp=v1 rd3 pc80", out_valid, out_rd, out_pc);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst2_no_replay got=%0b exp=0", out_valid); end
    endtask

`ifdef DECODE_PERF_CNT_EN
    task automatic test_perf_cnt();
        rst = 1'b1;
        drive(1'b0, 32'h0, 64'h0);
        tick();
        rst = 1'b0;
        checks++; if (retire_cnt !== 32'd0 || illegal_cnt !== 32'd0 || retire_cnt32 !== 32'd0) begin
            failures++; $display("FAIL perf_reset got=%0d/%0d/%0d exp=0/0/0", retire_cnt, illegal_cnt, retire_cnt32);
        end
        out_ready = 1'b1;
        drive(1'b1, 32'h00100093, 64'h0);
        tick();
        drive(1'b1, 32'h0000007F, 64'h4);
        tick();
        drive(1'b1, 32'h00100113, 64'h8);
        tick();
        drive(1'b1, 32'h00100193, 64'hC);
        tick();
        drive(1'b0, 32'h0, 64'h0);
        tick();
        tick();
        checks++; if (retire_cnt !== 32'd4) begin failures++; $display("FAIL perf_retire got=%0d exp=4", retire_cnt); end
        checks++; if (illegal_cnt !== 32'd1) begin failures++; $display("FAIL perf_illegal got=%0d exp=1", illegal_cnt); end
        checks++; if (illegal_cnt32 !== 32'd0) begin failures++; $display("FAIL perf_idle32 got=%0d exp=0", illegal_cnt32); end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_instr    = '0;
        in_pc       = '0;
        out_ready   = 1'b1;
        in_valid32  = 1'b0;
        in_instr32  = '0;
        in_pc32     = '0;
        out_ready32 = 1'b1;

        test_reset();
        test_addi();
        test_branch();
        test_store();
        test_back_to_back();
        test_backpressure();
        test_reset_in_two();
`ifdef DECODE_PERF_CNT_EN
        test_perf_cnt();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Parametrised, registered RISC-V decode stage. Sits between instruction fetch and register-read/ALU.
- Turns a 32-bit instruction plus its PC into register indices, control strobes, a sign-extended immediate and a PC-relative target.
- Covers all base formats (R/I/S/B/U/J). Immediates are built combinationally from the instruction itself.
- Uses a valid/ready handshake with a skid buffer, so it sustains one instruction per clock under backpressure.

Parameters:
- XLEN, 64, datapath width of imm, pc and target; legal values 32 or 64.
- RESET_PC_TAG, 0, value driven on out_pc while out_valid=0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active high.
- in_valid  in  1  instruction/PC present.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts bundle.
- out_pc  out  XLEN  PC of decoded instruction.
- out_rs1, out_rs2, out_rd  out  5 each  register indices: instr[19:15], instr[24:20], instr[11:7].
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_imm  out  XLEN  sign-extended immediate.
- out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN.
- out_fmt  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=none.
- out_alu_src, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write, out_branch, out_jump  out  1 each  control strobes.
- out_alu_op  out  2  00=add, 01=branch compare, 10=funct-decoded, 11=pass imm (LUI).
- out_illegal  out  1  instruction not supported.

Behaviour:
- Reset (rst=1 at a rising edge):
  - out_valid=0, skid buffer empty, in_ready=1.
  - All out_* strobes 0, out_imm=0, out_target=0, out_fmt=7, out_pc=RESET_PC_TAG.
  - Reset mid-transfer discards both the output register and the skid entry; nothing is replayed.
- Latency: one clock from an accepted input (in_valid & in_ready) to out_valid.
- Handshake:
  - Output register updates when out_valid=0 or out_ready=1.
  - in_ready = ~skid_full.
  - If an input is accepted while the output is held (out_valid=1, out_ready=0), it is decoded into the skid entry. The skid entry moves to the output on the next out_ready=1 before any new input.
  - States: EMPTY (out_valid=0) -> ONE (output valid) -> TWO (output + skid).
  - TWO -> ONE on out_ready. ONE -> EMPTY on out_ready with no input. Simultaneous accept and drain in ONE stays in ONE.
  - Bundle fields are stable while out_valid=1 and out_ready=0.
- Opcode decode:
  - 0110011: R, alu_op=10, reg_write.
  - 0010011: I, alu_src, alu_op=10, reg_write.
  - 0000011: I, alu_src, mem_read, mem_to_reg, reg_write.
  - 0100011: S, alu_src, mem_write.
  - 1100011: B, branch, alu_op=01.
  - 0110111 LUI: U, alu_src, alu_op=11, reg_write.
  - 0010111 AUIPC: U, reg_write; target used as the result.
  - 1101111 JAL: J, jump, reg_write.
  - 1100111 JALR: I, jump, alu_src, reg_write.
- Immediates: sign bit is always instr[31], taken from the current instruction only, never from a registered value.
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R: imm=0.
- Illegal conditions:
  - Unknown opcode.
  - instr[1:0]!=11.
  - Branch funct3 010 or 011.
  - Load funct3 111, or 011/110 when XLEN=32.
  - Store funct3 >011, or 011 when XLEN=32.
  - On illegal: out_illegal=1, out_fmt=7, and all mem/reg/branch/jump strobes forced 0. The bundle still flows through the handshake.
- rd=0: out_reg_write forced 0.
- out_target wraps silently on overflow or underflow.

Optional Feature:
- DECODE_PERF_CNT_EN defined:
  - Adds ports out_retire_cnt (out, 32) and out_illegal_cnt (out, 32), both cleared by rst.
  - out_retire_cnt increments on each out_valid & out_ready.
  - out_illegal_cnt increments on each such transfer with out_illegal=1.
  - Both saturate at 0xFFFFFFFF.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- addi x5,x0,-1 (0xFFF00293), XLEN=64, out_ready=1 -> next cycle:
  - out_valid=1, out_fmt=1, out_imm=0xFFFFFFFFFFFFFFFF, out_rd=5.
  - out_alu_src=1, out_reg_write=1.
- beq x1,x2,-8 (0xFE208CE3) at in_pc=0x100 -> out_fmt=3, out_imm=-8, out_target=0xF8, out_branch=1, out_reg_write=0.
- sd x3,16(x2) (0x00313823) with XLEN=64 -> out_imm=16, out_mem_write=1. The same word with XLEN=32 -> out_illegal=1, out_mem_write=0.
- Backpressure:
  - Stream 3 instructions with out_ready=0 -> two accepted, in_ready=0 on the third.
  - Raise out_ready -> outputs appear in order, one per cycle, none lost or duplicated.
- rst asserted while in state TWO -> next cycle out_valid=0, in_ready=1, all strobes 0. The first post-reset input appears one cycle after acceptance.
- With DECODE_PERF_CNT_EN: 4 transfers including 1 opcode 0x7F -> out_retire_cnt=4, out_illegal_cnt=1.
